truth_table_checker: RTL
========================

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter EXP_TT, default 8'hE8, SHALL hold the expected truth table; bit index = {a,b,c}, with a as MSB.
REQ-002 Parameter SETTLE, default 2, SHALL set the number of stable cycles required before y is sampled (range 1..15).
REQ-003 Parameter ERR_W, default 8, SHALL set the width of the error counter.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-006 start  in  1  SHALL be a one-cycle request that begins a check run.
REQ-007 a, b, c  in  1 each  SHALL be the stimulus vector driven to the DUT.
REQ-008 y  in  1  SHALL be the DUT response.
REQ-009 busy  out  1  SHALL be high in SETTLE, SAMPLE and WAIT_CHG.
REQ-010 done  out  1  SHALL be high in DONE.
REQ-011 pass  out  1  SHALL equal done AND (err_cnt==0).
REQ-012 err_cnt  out  ERR_W  SHALL be the mismatch count.
REQ-013 cov  out  8  SHALL flag the minterms checked in the current run.
REQ-014 first_err_vld, first_err_idx[2:0], first_err_y  out  SHALL report the first mismatch of the run (see REQ-032).

Function
REQ-015 The FSM SHALL have the states IDLE, SETTLE, SAMPLE, WAIT_CHG and DONE; the register prev[2:0] SHALL hold the last accepted {a,b,c}.
REQ-016 In IDLE or DONE, start=1 SHALL clear err_cnt, cov and the first-error registers, load prev={a,b,c}, load the counter with SETTLE, and enter SETTLE.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 In SETTLE, if {a,b,c}!=prev, the block SHALL set prev={a,b,c} and reload the counter with SETTLE (glitch restart).
REQ-019 In SETTLE, if the inputs are stable, the counter SHALL decrement; the transition to SAMPLE SHALL occur on the edge at which the counter reaches 0.
REQ-020 Latency: y SHALL be sampled exactly SETTLE+1 edges after the edge that accepted the last input change.
REQ-021 SAMPLE SHALL last one cycle: idx=prev; if y!=EXP_TT[idx], err_cnt SHALL increment; cov[idx] SHALL be set to 1.
REQ-022 err_cnt SHALL saturate at all-ones and never wrap.
REQ-023 After SAMPLE, the FSM SHALL enter DONE if cov (including the update from REQ-021) equals 8'hFF; otherwise it SHALL enter WAIT_CHG.
REQ-024 In WAIT_CHG, {a,b,c}!=prev SHALL set prev, reload the counter and enter SETTLE; an unchanged vector SHALL never be resampled.
REQ-025 A revisited minterm SHALL be rechecked and its errors counted again; cov SHALL be unaffected.
REQ-026 In DONE, all outputs SHALL hold their values until start or rst.
REQ-027 On a simultaneous input change and counter==0 in SETTLE, the change SHALL win: the counter reloads and no sample is taken.

Reset
REQ-028 rst=1 SHALL, on the clock edge, force IDLE with busy=0, done=0, pass=0, err_cnt=0, cov=0, first_err_*=0 and prev=0.
REQ-029 rst SHALL override start and any in-progress run, including mid-SETTLE.

Configuration
REQ-030 The macro TT_CHECK_FIRST_ERR_EN SHALL enable first-error capture.
REQ-031 With the macro undefined, first_err_vld, first_err_idx and first_err_y SHALL be tied to 0 and no capture registers SHALL be built.
REQ-032 With the macro defined, the first mismatch in SAMPLE while first_err_vld=0 SHALL set first_err_vld=1, first_err_idx=idx and first_err_y=y; later mismatches SHALL be ignored until the next start.

Verification
REQ-033 Default parameters, majority DUT, pulse start, then sweep {a,b,c} 0..7 holding each for 10 cycles -> done=1, pass=1, err_cnt=0, cov=8'hFF, busy=0.
REQ-034 As REQ-033 but y inverted at idx 5 -> err_cnt=1, pass=0; with the macro, first_err_vld=1, first_err_idx=5, first_err_y=0.
REQ-035 Toggle c every cycle for 4 cycles, then hold -> no SAMPLE until SETTLE+1 edges after the last toggle; cov gains exactly one bit.
REQ-036 ERR_W=2, y stuck wrong, sweep twice -> err_cnt=3 (saturated), no wrap.
REQ-037 rst asserted mid-SETTLE -> the next cycle shows the IDLE state with all outputs 0; start during busy -> no effect on err_cnt or cov.

Source files
------------

// File: rtl/truth_table_checker.sv
// Checks a 3-input combinational DUT against an expected truth table, waiting for
// the inputs to settle before sampling y. Optional first-error capture: TT_CHECK_FIRST_ERR_EN.
module truth_table_checker #(
    parameter logic [7:0] EXP_TT = 8'hE8,
    parameter int         SETTLE = 2,
    parameter int         ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       cov,
    output logic             first_err_vld,
    output logic [2:0]       first_err_idx,
    output logic             first_err_y
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_WAIT_CHG,
        ST_DONE
    } state_t;

    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_t           state_reg, state_next;
    logic [2:0]       prev_reg, prev_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [ERR_W-1:0] err_reg, err_next;
    logic [7:0]       cov_reg, cov_next;

    logic [2:0] vec;
    logic       vec_chg;
    logic       start_ok;
    logic       mismatch;
    logic [7:0] idx_onehot;
    logic [7:0] cov_upd;

    assign vec      = {a, b, c};
    assign vec_chg  = (vec != prev_reg);
    assign start_ok = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign mismatch = (state_reg == ST_SAMPLE) && (y != EXP_TT[prev_reg]);

    // Decode of the minterm currently being sampled, used to set its coverage bit.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_onehot
            assign idx_onehot[gi] = (prev_reg == 3'(gi));
        end
    endgenerate

    assign cov_upd = cov_reg | idx_onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            prev_reg  <= 3'd0;
            cnt_reg   <= 4'd0;
            err_reg   <= '0;
            cov_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            prev_reg  <= prev_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            cov_reg   <= cov_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        prev_next  = prev_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        cov_next   = cov_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_SETTLE;
                    prev_next  = vec;
                    cnt_next   = SETTLE_LD;
                    err_next   = '0;
                    cov_next   = 8'd0;
                end
            end
            ST_SETTLE: begin
                // An input change always wins over the countdown finishing.
                if (vec_chg) begin
                    prev_next = vec;
                    cnt_next  = SETTLE_LD;
                end else if (cnt_reg <= 4'd1) begin
                    cnt_next   = 4'd0;
                    state_next = ST_SAMPLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch && (err_reg != ERR_MAX)) begin
                    err_next = err_reg + 1'b1;
                end
                cov_next   = cov_upd;
                state_next = (cov_upd == 8'hFF) ? ST_DONE : ST_WAIT_CHG;
            end
            ST_WAIT_CHG: begin
                if (vec_chg) begin
                    prev_next  = vec;
                    cnt_next   = SETTLE_LD;
                    state_next = ST_SETTLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_reg == ST_SETTLE) || (state_reg == ST_SAMPLE) ||
                     (state_reg == ST_WAIT_CHG);
    assign done    = (state_reg == ST_DONE);
    assign pass    = done && (err_reg == '0);
    assign err_cnt = err_reg;
    assign cov     = cov_reg;

`ifdef TT_CHECK_FIRST_ERR_EN
    logic       fe_vld_reg;
    logic [2:0] fe_idx_reg;
    logic       fe_y_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fe_vld_reg <= 1'b0;
            fe_idx_reg <= 3'd0;
            fe_y_reg   <= 1'b0;
        end else if (start_ok) begin
            fe_vld_reg <= 1'b0;
            fe_idx_reg <= 3'd0;
            fe_y_reg   <= 1'b0;
        end else if (mismatch && !fe_vld_reg) begin
            fe_vld_reg <= 1'b1;
            fe_idx_reg <= prev_reg;
            fe_y_reg   <= y;
        end
    end

    assign first_err_vld = fe_vld_reg;
    assign first_err_idx = fe_idx_reg;
    assign first_err_y   = fe_y_reg;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign first_err_vld   = 1'b0;
    assign first_err_idx   = 3'd0;
    assign first_err_y     = 1'b0;
`endif

endmodule
